// File: rtl/aurora_tx_framer.sv
// Aurora-style lane TX framer: selects one 8b10b symbol per cycle (idle, SCP,
// payload, ECP or clock-compensation) for the downstream encoder. The encoder
// keeps running disparity; this block only chooses data/ctrl.
module aurora_tx_framer #(
  parameter int G_CC_PERIOD = 5000,
  parameter int G_CC_LEN    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic [7:0]  data_o,
  output logic        ctrl_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);

  localparam int TIMER_W = $clog2(G_CC_PERIOD);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(G_CC_PERIOD - 1);
  localparam logic [3:0] BURST_LEN = 4'(G_CC_LEN);

  localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5
  localparam logic [7:0] K_SCP1 = 8'h5C;  // K28.2
  localparam logic [7:0] K_SCP2 = 8'hFB;  // K27.7
  localparam logic [7:0] K_ECP1 = 8'hFD;  // K29.7
  localparam logic [7:0] K_ECP2 = 8'hFE;  // K30.7
  localparam logic [7:0] K_CC   = 8'hF7;  // K23.7

  typedef enum logic [2:0] {
    IDLE,
    SCP2,
    DATA,
    ECP1,
    ECP2,
    CC
  } state_t;

  state_t                 state;
  logic [TIMER_W-1:0]     cc_timer;
  logic                   cc_wrap;
  logic                   cc_pend;
  logic [3:0]             burst_cnt;

  assign cc_wrap = (cc_timer == TIMER_LAST);

  // Bytes are taken only in DATA; reset drops ready immediately so no byte
  // is consumed by a frame that is being aborted.
  assign s_ready_o = (state == DATA) && !rst_i;
  assign busy_o    = (state != IDLE);

  // Free-running clock-compensation timer, independent of en_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cc_timer <= '0;
    end else if (cc_wrap) begin
      cc_timer <= '0;
    end else begin
      cc_timer <= cc_timer + 1'b1;
    end
  end

  // Framing FSM with registered symbol outputs and CC request bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      data_o      <= K_IDLE;
      ctrl_o      <= 1'b1;
      cc_pend     <= 1'b0;
      burst_cnt   <= '0;
      frame_cnt_o <= '0;
    end else begin
      data_o <= K_IDLE;
      ctrl_o <= 1'b1;
      case (state)
        IDLE: begin
          // CC wins over a waiting frame; a frame start does not consume
          // the first byte, it is taken once DATA is reached.
          if (en_i && cc_pend) begin
            data_o    <= K_CC;
            cc_pend   <= 1'b0;
            burst_cnt <= 4'd1;
            if (G_CC_LEN > 1) begin
              state <= CC;
            end
          end else if (en_i && s_valid_i) begin
            data_o <= K_SCP1;
            state  <= SCP2;
          end
        end
        SCP2: begin
          data_o <= K_SCP2;
          state  <= DATA;
        end
        DATA: begin
          // Underrun inside a frame is filled with idles.
          if (s_valid_i) begin
            data_o <= s_data_i;
            ctrl_o <= 1'b0;
            if (s_last_i) begin
              state <= ECP1;
            end
          end
        end
        ECP1: begin
          data_o <= K_ECP1;
          state  <= ECP2;
        end
        ECP2: begin
          data_o      <= K_ECP2;
          frame_cnt_o <= frame_cnt_o + 16'd1;
          state       <= IDLE;
        end
        CC: begin
          data_o    <= K_CC;
          burst_cnt <= burst_cnt + 4'd1;
          if ((burst_cnt + 4'd1) == BURST_LEN) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // A new request landing in the same cycle one is served is kept;
      // a request while one is already pending simply merges.
      if (cc_wrap) begin
        cc_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Testbench for aurora_tx_framer: directed reference frame plus randomized
// traffic (gaps, en toggles, resets) checked against a symbol-queue model.
module tb_aurora_tx_framer;

  localparam int P = 8;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  data;
  logic        ctrl;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  aurora_tx_framer #(
    .G_CC_PERIOD(P),
    .G_CC_LEN   (L)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .s_data_i   (s_data),
    .s_valid_i  (s_valid),
    .s_last_i   (s_last),
    .s_ready_o  (s_ready),
    .data_o     (data),
    .ctrl_o     (ctrl),
    .busy_o     (busy),
    .frame_cnt_o(frame_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: fixed K sequences (SCP tail, ECP, CC burst) are queued
  // and drained one per cycle; payload flows straight from the inputs.
  logic [7:0] m_q[$];
  bit         m_in_frame;
  bit         m_pend;
  int         m_timer;
  logic [7:0] m_data;
  bit         m_ctrl;
  int         m_cnt;

  function automatic void m_step();
    bit wrap;
    if (rst) begin
      m_q.delete();
      m_in_frame = 0;
      m_pend     = 0;
      m_timer    = 0;
      m_data     = 8'hBC;
      m_ctrl     = 1;
      m_cnt      = 0;
      return;
    end
    wrap    = (m_timer == P - 1);
    m_timer = wrap ? 0 : m_timer + 1;
    m_data  = 8'hBC;
    m_ctrl  = 1;
    if (m_q.size() > 0) begin
      m_data = m_q.pop_front();
      if (m_data == 8'hFB) m_in_frame = 1;
      if (m_data == 8'hFE) m_cnt = (m_cnt + 1) % 65536;
    end else if (m_in_frame) begin
      if (s_valid) begin
        m_data = s_data;
        m_ctrl = 0;
        if (s_last) begin
          m_in_frame = 0;
          m_q.push_back(8'hFD);
          m_q.push_back(8'hFE);
        end
      end
    end else if (en && m_pend) begin
      m_data = 8'hF7;
      m_pend = 0;
      for (int k = 1; k < L; k++) m_q.push_back(8'hF7);
    end else if (en && s_valid) begin
      m_data = 8'h5C;
      m_q.push_back(8'hFB);
    end
    if (wrap) m_pend = 1;
  endfunction

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic cycle(output bit acc);
    #1;
    check("ready", s_ready, !rst && m_in_frame);
    acc = s_valid && !rst && m_in_frame;
    @(posedge clk);
    m_step();
    #1;
    check("data", data, m_data);
    check("ctrl", ctrl, m_ctrl);
    check("busy", busy, m_in_frame || (m_q.size() > 0));
    check("frame_cnt", frame_cnt, m_cnt);
  endtask

  logic [7:0] dir_bytes[3];
  logic [7:0] dir_exp[8];
  logic [8:0] src_q[$];

  initial begin
    bit acc;
    int bi;
    dir_bytes = '{8'h11, 8'h22, 8'h33};
    dir_exp   = '{8'h5C, 8'hFB, 8'h11, 8'h22, 8'h33, 8'hFD, 8'hFE, 8'hBC};

    rst = 1; en = 1; s_valid = 0; s_last = 0; s_data = 8'h00;
    @(posedge clk);
    cycle(acc);
    cycle(acc);
    check("rst_data", data, 8'hBC);
    check("rst_ctrl", ctrl, 1);
    check("rst_cnt", frame_cnt, 0);
    rst = 0;

    // Three-byte frame straight out of reset, valid held throughout.
    bi = 0;
    for (int i = 0; i < 8; i++) begin
      s_valid = (bi < 3);
      s_data  = (bi < 3) ? dir_bytes[bi] : 8'h00;
      s_last  = (bi == 2);
      cycle(acc);
      if (acc) bi++;
      check("dir_seq", data, dir_exp[i]);
    end
    check("dir_frames", frame_cnt, 1);
    s_valid = 0;

    // Randomized traffic: payload gaps, en toggles, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en = ($urandom_range(0, 4) != 0);
      if (src_q.size() == 0) begin
        int len;
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) src_q.push_back({k == len - 1, 8'($urandom)});
      end
      s_valid = ($urandom_range(0, 3) != 0);
      if (s_valid) begin
        {s_last, s_data} = src_q[0];
      end else begin
        s_last = 1'($urandom);
        s_data = 8'($urandom);
      end
      cycle(acc);
      if (acc) void'(src_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
